dest_reg_tracker: RTL and testbench
===================================

// Module: dest_reg_tracker
// PURPOSE
//  Consumer end of the EX-stage destination-register select (Rt/Rd under RegDst).
//  Carries the selected write-register number and its write/load flags through
//  EX/MEM and MEM/WB, and drives the register-file write address at WB.
//  Compares in-flight destinations against source registers to produce forwarding
//  selects for EX operands and the load-use stall for ID.
//  Counts stall cycles for performance monitoring.
// PARAMETERS
//  REG_W    5   register-number width
//  CNT_W    16  width of the saturating stall counter
//  ZERO_REG 0   index of hardwired zero register; never forwarded, never stalls
// PORTS
//  clk             in  1      rising-edge clock
//  rst_n           in  1      synchronous reset, active low
//  ex_valid        in  1      EX holds a real instruction (0 = bubble)
//  ex_dest         in  REG_W  destination selected by the RegDst mux
//  ex_reg_write    in  1      EX instruction writes the register file
//  ex_mem_read     in  1      EX instruction is a load
//  ex_flush        in  1      kill EX instruction (branch/exception)
//  ex_rs           in  REG_W  EX operand A source register
//  ex_rt           in  REG_W  EX operand B source register
//  id_rs           in  REG_W  ID source register 1
//  id_rt           in  REG_W  ID source register 2
//  fwd_a           out 2      operand A: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b           out 2      operand B: same encoding
//  load_use_stall  out 1      freeze PC/IF-ID, bubble into EX
//  mem_dest        out REG_W  EX/MEM destination
//  mem_reg_write   out 1      EX/MEM write enable (qualified)
//  wb_dest         out REG_W  register-file write address
//  wb_reg_write    out 1      register-file write enable (qualified)
//  stall_count     out CNT_W  saturating count of load_use_stall cycles
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): mem_*/wb_* dest=0, write=0, mem_load=0,
//    stall_count=0. Comb outputs then read fwd_a=fwd_b=00, load_use_stall=0.
//  - Reset dominates; applied mid-operation, all in-flight writes discarded.
//  - Every posedge: MEM <= {ex_dest, ex_valid&ex_reg_write&~ex_flush,
//    ex_valid&ex_mem_read&~ex_flush}; WB <= MEM. No hold; 1-cycle latency per stage.
//  - Write enable to any stage forced 0 if dest==ZERO_REG (no write to r0).
//  - Forwarding is combinational from current stage regs. Per operand src:
//    EX/MEM hit when mem_reg_write & mem_dest==src -> 10.
//    Else MEM/WB hit when wb_reg_write & wb_dest==src -> 01.
//    Else -> 00. EX/MEM has priority when both match.
//  - src==ZERO_REG always yields 00.
//  - load_use_stall = ex_valid & ex_mem_read & ~ex_flush & ex_dest!=ZERO_REG &
//    (ex_dest==id_rs | ex_dest==id_rt). Combinational, same cycle.
//  - Flush and load match in the same cycle: flush wins, no stall.
//  - stall_count increments at each posedge where load_use_stall=1.
//    It saturates at all-ones and never wraps.
//  - Upstream converts a stall into a bubble (ex_valid=0) next cycle.
//    This block never self-holds.
// TESTING
//  1 Reset: rst_n=0 two cycles with random inputs -> all outputs 0; wb_reg_write
//    stays 0 the first cycle after release.
//  2 Back-to-back ALU (add r3 then sub using r3 as rs): ex_dest=3, write=1;
//    next cycle ex_rs=3 -> fwd_a=10; following cycle ex_rt=3 -> fwd_b=01;
//    two cycles after issue wb_dest=3, wb_reg_write=1.
//  3 Double hit: r5 in both EX/MEM and MEM/WB, ex_rs=5 -> fwd_a=10 (newest wins).
//  4 Load-use: ex_mem_read=1, ex_dest=7, id_rt=7 -> load_use_stall=1 same cycle,
//    stall_count 0->1. Same with ex_flush=1 -> stall=0, count unchanged.
//  5 Zero register: ex_dest=0, write=1 -> mem_reg_write=0. Later ex_rs=0 -> fwd_a=00.
//    Load to r0 with id_rs=0 -> no stall.
//  6 Saturation (CNT_W=4): hold stall condition 20 cycles -> stall_count sticks at 15.
//    Reset mid-run -> 0.

Source files
------------

// File: rtl/dest_reg_tracker.sv
// -----------------------------------------------------------------------------
// dest_reg_tracker
//
// Purpose:
//   Consumer end of the EX-stage destination-register select. It carries the
//   selected write-register number and its qualified write flag through EX/MEM
//   and MEM/WB, and presents the MEM/WB copy as the register-file write port.
//   In-flight destinations are compared against the EX operand sources to pick
//   forwarding paths. The EX load destination is compared against the ID
//   sources to raise the load-use stall. Stall cycles are counted in a
//   saturating performance counter.
//
// Parameters:
//   REG_W     register-number width
//   CNT_W     width of the saturating stall counter
//   ZERO_REG  index of the hardwired zero register (never written/forwarded)
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   ex_valid          EX holds a real instruction (0 = bubble)
//   ex_dest           destination chosen by the RegDst mux
//   ex_reg_write      EX instruction writes the register file
//   ex_mem_read       EX instruction is a load
//   ex_flush          kill the EX instruction
//   ex_rs, ex_rt      EX operand source registers
//   id_rs, id_rt      ID source registers
//   fwd_a, fwd_b      operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   load_use_stall    freeze PC/IF-ID and bubble EX
//   mem_dest          EX/MEM destination
//   mem_reg_write     EX/MEM write enable (qualified)
//   wb_dest           register-file write address
//   wb_reg_write      register-file write enable (qualified)
//   stall_count       saturating count of load_use_stall cycles
// -----------------------------------------------------------------------------
module dest_reg_tracker #(
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_flush,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             load_use_stall,
    output logic [REG_W-1:0] mem_dest,
    output logic             mem_reg_write,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_reg_write,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [REG_W-1:0] ZERO    = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX)
            return val;
        return val + CNT_W'(1);
    endfunction

    // Newest producer wins: EX/MEM is checked before MEM/WB. The zero register
    // always reads from the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] m_dest,
        input logic             m_wr,
        input logic [REG_W-1:0] w_dest,
        input logic             w_wr
    );
        if (src == ZERO)
            return 2'b00;
        if (m_wr && (m_dest == src))
            return 2'b10;
        if (w_wr && (w_dest == src))
            return 2'b01;
        return 2'b00;
    endfunction

    logic ex_live;
    logic ex_write;

    // An instruction only counts if it is real and not being killed.
    assign ex_live  = ex_valid & ~ex_flush;
    // Writes to the zero register are dropped at entry, so no later stage
    // ever carries a live write to it.
    assign ex_write = ex_live & ex_reg_write & (ex_dest != ZERO);

    // ---- EX -> EX/MEM -> MEM/WB ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_dest      <= '0;
            mem_reg_write <= 1'b0;
            wb_dest       <= '0;
            wb_reg_write  <= 1'b0;
        end else begin
            mem_dest      <= ex_dest;
            mem_reg_write <= ex_write;
            wb_dest       <= mem_dest;
            wb_reg_write  <= mem_reg_write;
        end
    end

    // ---- forwarding and hazard detection (combinational) ----
    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_dest, mem_reg_write, wb_dest, wb_reg_write);
        fwd_b = fwd_sel(ex_rt, mem_dest, mem_reg_write, wb_dest, wb_reg_write);
        // Held low during reset so a stray load in EX cannot freeze the front end.
        load_use_stall = rst_n & ex_live & ex_mem_read & (ex_dest != ZERO) &
                         ((ex_dest == id_rs) | (ex_dest == id_rt));
    end

    // ---- performance counter ----
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if (load_use_stall)
            stall_count <= sat_inc(stall_count);
    end

endmodule

// File: tb/tb_dest_reg_tracker.sv
// -----------------------------------------------------------------------------
// tb_dest_reg_tracker
//
// Directed stimulus for dest_reg_tracker. Each driven cycle queues its
// hand-computed expected outputs (-1 = not checked); an independent monitor
// pops one entry per cycle on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_dest_reg_tracker;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ex_valid = 1'b0;
    logic [REG_W-1:0] ex_dest = '0;
    logic             ex_reg_write = 1'b0;
    logic             ex_mem_read = 1'b0;
    logic             ex_flush = 1'b0;
    logic [REG_W-1:0] ex_rs = '0;
    logic [REG_W-1:0] ex_rt = '0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             load_use_stall;
    logic [REG_W-1:0] mem_dest;
    logic             mem_reg_write;
    logic [REG_W-1:0] wb_dest;
    logic             wb_reg_write;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    dest_reg_tracker #(.REG_W(REG_W), .CNT_W(CNT_W), .ZERO_REG(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_dest        (ex_dest),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_flush       (ex_flush),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .load_use_stall (load_use_stall),
        .mem_dest       (mem_dest),
        .mem_reg_write  (mem_reg_write),
        .wb_dest        (wb_dest),
        .wb_reg_write   (wb_reg_write),
        .stall_count    (stall_count)
    );

    typedef struct {
        int id;
        bit rst_n, valid, rw, mr, fl;
        int dest, rs, rt, irs, irt;
        int fa, fb, st, md, mw, wd, ww, cnt;
    } vec_t;

    vec_t expq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    function automatic vec_t idle();
        vec_t v;
        v.id = 0;
        v.rst_n = 1'b1; v.valid = 1'b0; v.rw = 1'b0; v.mr = 1'b0; v.fl = 1'b0;
        v.dest = 0; v.rs = 0; v.rt = 0; v.irs = 0; v.irt = 0;
        v.fa = -1; v.fb = -1; v.st = -1; v.md = -1; v.mw = -1;
        v.wd = -1; v.ww = -1; v.cnt = -1;
        return v;
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue its expectations.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst_n        = v.rst_n;
        ex_valid     = v.valid;
        ex_reg_write = v.rw;
        ex_mem_read  = v.mr;
        ex_flush     = v.fl;
        ex_dest      = REG_W'(v.dest);
        ex_rs        = REG_W'(v.rs);
        ex_rt        = REG_W'(v.rt);
        id_rs        = REG_W'(v.irs);
        id_rt        = REG_W'(v.irt);
        cyc++;
        v.id = cyc;
        expq.push_back(v);
    endtask

    task automatic chk(input string nm, input int id, input int act, input int exp);
        if (exp < 0)
            return;
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL c%0d.%s: got %0d, expected %0d", id, nm, act, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled on the falling edge.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("fwd_a",          e.id, int'(fwd_a),          e.fa);
                chk("fwd_b",          e.id, int'(fwd_b),          e.fb);
                chk("load_use_stall", e.id, int'(load_use_stall), e.st);
                chk("mem_dest",       e.id, int'(mem_dest),       e.md);
                chk("mem_reg_write",  e.id, int'(mem_reg_write),  e.mw);
                chk("wb_dest",        e.id, int'(wb_dest),        e.wd);
                chk("wb_reg_write",   e.id, int'(wb_reg_write),   e.ww);
                chk("stall_count",    e.id, int'(stall_count),    e.cnt);
            end
        end
    end

    initial begin
        vec_t v;
        int   wait_cyc;

        // Reset held two cycles with random inputs: everything reads zero.
        for (int k = 0; k < 2; k++) begin
            v = idle();
            v.rst_n = 1'b0;
            v.valid = 1'($urandom); v.rw = 1'($urandom); v.mr = 1'($urandom);
            v.fl = 1'b0;
            v.dest = int'($urandom_range(1, 31));
            v.rs = v.dest; v.rt = v.dest; v.irs = v.dest; v.irt = v.dest;
            v.fa = 0; v.fb = 0; v.st = 0; v.md = 0; v.mw = 0;
            v.wd = 0; v.ww = 0; v.cnt = 0;
            apply(v);
        end
        // Release with a write to r9 issued in the same cycle.
        v = idle(); v.valid = 1; v.rw = 1; v.dest = 9;
        v.mw = 0; v.ww = 0; v.st = 0; v.cnt = 0;
        apply(v);
        v = idle(); v.md = 9; v.mw = 1; v.ww = 0;
        apply(v);
        v = idle(); v.wd = 9; v.ww = 1; v.mw = 0;
        apply(v);

        // Back-to-back ALU: add r3, then sub r4 reading r3.
        v = idle(); v.valid = 1; v.rw = 1; v.dest = 3;
        apply(v);
        v = idle(); v.valid = 1; v.rw = 1; v.dest = 4; v.rs = 3; v.rt = 2;
        v.fa = 2; v.fb = 0;
        apply(v);
        v = idle(); v.rt = 3;
        v.fa = 0; v.fb = 1; v.wd = 3; v.ww = 1; v.md = 4; v.mw = 1;
        apply(v);

        // Double hit on r5: newest (EX/MEM) wins; then MEM/WB alone.
        v = idle(); v.valid = 1; v.rw = 1; v.dest = 5;
        apply(v);
        v = idle(); v.valid = 1; v.rw = 1; v.dest = 5;
        apply(v);
        v = idle(); v.rs = 5; v.rt = 5;
        v.fa = 2; v.fb = 2; v.md = 5; v.mw = 1; v.wd = 5; v.ww = 1;
        apply(v);
        v = idle(); v.rs = 5;
        v.fa = 1; v.mw = 0;
        apply(v);

        // Load-use on id_rt, then the same load flushed.
        v = idle(); v.valid = 1; v.rw = 1; v.mr = 1; v.dest = 7; v.irs = 1; v.irt = 7;
        v.st = 1; v.cnt = 0;
        apply(v);
        v = idle(); v.st = 0; v.cnt = 1; v.md = 7; v.mw = 1;
        apply(v);
        v = idle(); v.valid = 1; v.rw = 1; v.mr = 1; v.fl = 1; v.dest = 7; v.irt = 7;
        v.st = 0; v.cnt = 1;
        apply(v);
        v = idle(); v.md = 7; v.mw = 0; v.cnt = 1;
        apply(v);

        // Zero register: write to r0 dropped, r0 never forwarded, load to r0 never stalls.
        v = idle(); v.valid = 1; v.rw = 1; v.dest = 0;
        apply(v);
        v = idle(); v.md = 0; v.mw = 0; v.fa = 0;
        apply(v);
        v = idle(); v.valid = 1; v.rw = 1; v.mr = 1; v.dest = 0; v.irs = 0; v.irt = 0;
        v.st = 0;
        apply(v);
        v = idle(); v.cnt = 1;
        apply(v);

        // Hold the stall 20 cycles: the 4-bit counter sticks at 15.
        for (int k = 1; k <= 20; k++) begin
            v = idle(); v.valid = 1; v.rw = 1; v.mr = 1; v.dest = 7; v.irs = 7;
            v.st = 1; v.cnt = (k < 15) ? k : 15;
            apply(v);
        end
        // Reset mid-run: in-flight writes and the counter are cleared.
        v = idle(); v.rst_n = 0; v.st = 0; v.cnt = 15; v.md = 7; v.mw = 1;
        apply(v);
        v = idle(); v.cnt = 0; v.md = 0; v.mw = 0; v.wd = 0; v.ww = 0;
        apply(v);
        v = idle(); v.ww = 0; v.cnt = 0;
        apply(v);

        // Let the monitor drain, bounded.
        wait_cyc = 0;
        while (expq.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        n_cmp++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
